// File: rtl/ctl_pkt_pkg.sv
// Control-packet chain definitions: beat tags, type codes, field positions and the
// head-beat builder shared by modules that initiate or answer register commands.
package ctl_pkt_pkg;

    localparam int BEAT_W = 134;

    localparam int TAG_HI  = 133;
    localparam int TAG_LO  = 132;
    localparam int TYPE_HI = 127;
    localparam int TYPE_LO = 124;
    localparam int SRC_HI  = 111;
    localparam int SRC_LO  = 104;
    localparam int DST_HI  = 103;
    localparam int DST_LO  = 96;
    localparam int ADDR_HI = 95;
    localparam int ADDR_LO = 64;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_TAIL = 2'b10;
    localparam logic [2:0] TYPE_RD  = 3'b001;
    localparam logic [2:0] TYPE_WR  = 3'b010;
    localparam logic [3:0] TYPE_RSP = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_TAIL,
        ST_WAIT_RSP,
        ST_RSP_TAIL,
        ST_DONE
    } mst_state_e;

    function automatic logic [BEAT_W-1:0] mk_head(
        input logic        rd,
        input logic [7:0]  src,
        input logic [7:0]  dst,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        logic [BEAT_W-1:0] b;
        b = '0;
        b[TAG_HI:TAG_LO]   = TAG_HEAD;
        b[TYPE_HI:TYPE_LO] = {1'b0, (rd ? TYPE_RD : TYPE_WR)};
        b[SRC_HI:SRC_LO]   = src;
        b[DST_HI:DST_LO]   = dst;
        b[ADDR_HI:ADDR_LO] = addr;
        b[DATA_HI:DATA_LO] = rd ? 32'h0 : wdata;
        return b;
    endfunction

endpackage

// File: rtl/ctl_reg_master.sv
// Register-command initiator for the control-packet chain: emits head+tail beats and,
// for reads, waits (with timeout) for the matching response to come back around.
module ctl_reg_master
    import ctl_pkt_pkg::*;
#(
    parameter logic [7:0] SRC_MID     = 8'd1,
    parameter int         TIMEOUT_CYC = 1024,
    parameter int         TO_W        = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_rd,
    input  logic [7:0]        i_cmd_dst_mid,
    input  logic [31:0]       i_cmd_addr,
    input  logic [31:0]       i_cmd_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [BEAT_W-1:0] o_cout_ctl_data,
    output logic              o_cout_ctl_wr,
    input  logic              i_cin_ctl_ready,
    input  logic [BEAT_W-1:0] i_cin_ctl_data,
    input  logic              i_cin_ctl_wr,
    output logic              o_cout_ctl_ready,
    output logic [15:0]       o_drop_cnt
);

    mst_state_e        r_state;
    logic              r_rd;
    logic [7:0]        r_dst;
    logic [31:0]       r_addr;
    logic [31:0]       r_cap;
    logic [BEAT_W-1:0] r_cout_data;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [TO_W-1:0]   r_to_cnt;
    logic [15:0]       r_drop;

    logic w_fire;
    logic w_match;
    logic w_tail_in;
    logic w_consume;
    logic w_to_last;
    logic w_unused;

    // A beat leaves only in a cycle the downstream can take it; data itself is registered.
    assign w_fire = i_cin_ctl_ready && (r_state == ST_HEAD || r_state == ST_TAIL);

    assign w_match = i_cin_ctl_wr
                  && i_cin_ctl_data[TAG_HI:TAG_LO]   == TAG_HEAD
                  && i_cin_ctl_data[TYPE_HI:TYPE_LO] == TYPE_RSP
                  && i_cin_ctl_data[DST_HI:DST_LO]   == SRC_MID
                  && i_cin_ctl_data[SRC_HI:SRC_LO]   == r_dst
                  && i_cin_ctl_data[ADDR_HI:ADDR_LO] == r_addr;

    assign w_tail_in = i_cin_ctl_wr && i_cin_ctl_data[TAG_HI:TAG_LO] == TAG_TAIL;
    assign w_consume = (r_state == ST_WAIT_RSP && w_match)
                    || (r_state == ST_RSP_TAIL && w_tail_in);
    assign w_to_last = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    assign w_unused = ^{i_cin_ctl_data[131:128], i_cin_ctl_data[123:112],
                        i_cin_ctl_data[63:32]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_rd        <= 1'b0;
            r_dst       <= '0;
            r_addr      <= '0;
            r_cap       <= '0;
            r_cout_data <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_to_cnt    <= '0;
            r_drop      <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (i_cin_ctl_wr && !w_consume && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;

            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_rd        <= i_cmd_rd;
                        r_dst       <= i_cmd_dst_mid;
                        r_addr      <= i_cmd_addr;
                        r_cout_data <= mk_head(i_cmd_rd, SRC_MID, i_cmd_dst_mid,
                                               i_cmd_addr, i_cmd_wdata);
                        r_state     <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (w_fire) begin
                        r_cout_data <= {TAG_TAIL, {(BEAT_W-2){1'b0}}};
                        r_state     <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (w_fire) begin
                        r_cout_data <= '0;
                        r_to_cnt    <= '0;
                        if (r_rd) begin
                            r_state <= ST_WAIT_RSP;
                        end else begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b0;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    // A match on the final timeout cycle still counts as success.
                    if (w_match) begin
                        r_cap   <= i_cin_ctl_data[DATA_HI:DATA_LO];
                        r_state <= ST_RSP_TAIL;
                    end else if (w_to_last) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= 32'hFFFF_FFFF;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_RSP_TAIL: begin
                    if (w_tail_in) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_cap;
                        r_rsp_err   <= 1'b0;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready      = (r_state == ST_IDLE);
    assign o_cout_ctl_wr    = w_fire;
    assign o_cout_ctl_data  = r_cout_data;
    assign o_cout_ctl_ready = 1'b1;
    assign o_rsp_valid      = r_rsp_valid;
    assign o_rsp_rdata      = r_rsp_rdata;
    assign o_rsp_err        = r_rsp_err;
    assign o_drop_cnt       = r_drop;

endmodule

// File: tb/tb_ctl_reg_master.sv
// Directed bench for ctl_reg_master: expected beats/responses are queued from packet-format
// rules, the drop count is tallied per injected beat, and one process compares every cycle.
module tb_ctl_reg_master;

    localparam int TO = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_rd = 1'b0;
    logic [7:0]   cmd_dst = '0;
    logic [31:0]  cmd_addr = '0;
    logic [31:0]  cmd_wdata = '0;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [133:0] cout_data;
    logic         cout_wr;
    logic         cin_ready = 1'b1;
    logic [133:0] cin_data = '0;
    logic         cin_wr = 1'b0;
    logic         cout_ready;
    logic [15:0]  drop_cnt;

    ctl_reg_master #(.SRC_MID(8'd1), .TIMEOUT_CYC(TO), .TO_W(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rd(cmd_rd),
        .i_cmd_dst_mid(cmd_dst), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_cout_ctl_data(cout_data), .o_cout_ctl_wr(cout_wr), .i_cin_ctl_ready(cin_ready),
        .i_cin_ctl_data(cin_data), .i_cin_ctl_wr(cin_wr), .o_cout_ctl_ready(cout_ready),
        .o_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int m_drop = 0;
    int rsp_cyc = 0;
    int wr_cnt = 0;
    bit rsp_seen = 1'b0;
    logic [133:0] last_head = '0;
    logic [133:0] exp_beats[$];
    logic [32:0]  exp_rsp[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Packet images derived directly from the field layout.
    function automatic logic [133:0] m_head(input bit rd, input logic [7:0] dst,
                                            input logic [31:0] addr, input logic [31:0] wd);
        logic [133:0] b;
        b = '0;
        b[133:132] = 2'b01;
        b[127:124] = rd ? 4'h1 : 4'h2;
        b[111:104] = 8'd1;
        b[103:96]  = dst;
        b[95:64]   = addr;
        b[31:0]    = rd ? 32'h0 : wd;
        return b;
    endfunction

    function automatic logic [133:0] m_tail();
        logic [133:0] b;
        b = '0;
        b[133:132] = 2'b10;
        return b;
    endfunction

    function automatic logic [133:0] m_resp(input logic [7:0] src, input logic [31:0] addr,
                                            input logic [31:0] data);
        logic [133:0] b;
        b = '0;
        b[133:132] = 2'b01;
        b[127:124] = 4'hB;
        b[111:104] = src;
        b[103:96]  = 8'd1;
        b[95:64]   = addr;
        b[31:0]    = data;
        return b;
    endfunction

    // Compare process: every active cycle, DUT outputs against the bench's expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (cout_wr) begin
                logic [133:0] e;
                wr_cnt++;
                check("wr_without_ready", 134'(cin_ready), 134'(1));
                if (exp_beats.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat actual=%h required=none", cout_data);
                end else begin
                    e = exp_beats.pop_front();
                    check("beat", cout_data, e);
                    if (e[133:132] == 2'b01) last_head = cout_data;
                end
            end
            if (rsp_valid) begin
                rsp_seen = 1'b1;
                rsp_cyc  = cyc;
                if (exp_rsp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp actual=%h required=none", rsp_rdata);
                end else begin
                    check("rsp", 134'({rsp_err, rsp_rdata}), 134'(exp_rsp.pop_front()));
                end
            end
            check("drop_cnt", 134'(drop_cnt), 134'(m_drop));
            check("cout_ready", 134'(cout_ready), 134'(1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        cin_wr = 1'b0;
        cin_ready = 1'b1;
        step(2);
        check("rst_cmd_ready", 134'(cmd_ready), 134'(1));
        check("rst_cout_wr", 134'(cout_wr), 134'(0));
        check("rst_cout_data", cout_data, 134'(0));
        check("rst_rsp_valid", 134'(rsp_valid), 134'(0));
        check("rst_rsp_rdata", 134'(rsp_rdata), 134'(0));
        check("rst_rsp_err", 134'(rsp_err), 134'(0));
        check("rst_drop_cnt", 134'(drop_cnt), 134'(0));
        check("rst_cout_ready", 134'(cout_ready), 134'(1));
        exp_beats.delete();
        exp_rsp.delete();
        m_drop = 0;
        rsp_seen = 1'b0;
        wr_cnt = 0;
        rst = 1'b0;
    endtask

    // Called at #1 after an edge; returns the cycle in which the command was sampled.
    task automatic issue(input bit rd, input logic [7:0] dst, input logic [31:0] addr,
                         input logic [31:0] wd, output int acc);
        check("cmd_ready_idle", 134'(cmd_ready), 134'(1));
        exp_beats.push_back(m_head(rd, dst, addr, wd));
        exp_beats.push_back(m_tail());
        cmd_valid = 1'b1; cmd_rd = rd; cmd_dst = dst; cmd_addr = addr; cmd_wdata = wd;
        step(1);
        acc = cyc - 1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [133:0] b, input bit dropped);
        cin_data = b;
        cin_wr = 1'b1;
        @(posedge clk);
        if (dropped) m_drop++;
        #1;
        cin_wr = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int max);
        int n = 0;
        while (!rsp_seen && n < max) begin
            step(1);
            n++;
        end
        if (!rsp_seen) begin
            total++; bad++;
            $display("FAIL %s_no_rsp actual=timeout required=rsp_valid", name);
        end
    endtask

    int acc;

    initial begin
        do_reset();

        // Write: head/tail layout and 3-cycle latency.
        exp_rsp.push_back({1'b0, 32'h0});
        issue(1'b0, 8'd7, 32'h7000_0003, 32'h11, acc);
        wait_rsp("wr", 20);
        check("wr_latency", 134'(rsp_cyc - acc), 134'(3));
        check("wr_head_type", 134'(last_head[127:124]), 134'(4'h2));
        check("wr_head_dst", 134'(last_head[103:96]), 134'(8'd7));
        check("wr_head_src", 134'(last_head[111:104]), 134'(8'd1));
        check("wr_head_data", 134'(last_head[31:0]), 134'(32'h11));
        check("wr_rdata", 134'(rsp_rdata), 134'(0));
        check("wr_err", 134'(rsp_err), 134'(0));
        step(1);
        check("rsp_pulse", 134'(rsp_valid), 134'(0));

        // Read with response after 10 cycles; a busy-time command is ignored.
        do_reset();
        exp_rsp.push_back({1'b0, 32'h5});
        issue(1'b1, 8'd7, 32'h7000_000A, 32'h0, acc);
        step(2);
        cmd_valid = 1'b1; cmd_addr = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            check("busy_cmd_ready", 134'(cmd_ready), 134'(0));
            step(1);
        end
        cmd_valid = 1'b0;
        step(5);
        send_beat(m_resp(8'd7, 32'h7000_000A, 32'h0000_0005), 1'b0);
        send_beat(m_tail(), 1'b0);
        wait_rsp("rd", 20);
        check("rd_rdata", 134'(rsp_rdata), 134'(32'h5));
        check("rd_err", 134'(rsp_err), 134'(0));
        check("rd_drop", 134'(drop_cnt), 134'(0));
        check("rd_head_type", 134'(last_head[127:124]), 134'(4'h1));

        // Stall in HEAD: no beat while ready low, data held, head sent once.
        do_reset();
        cin_ready = 1'b0;
        issue(1'b1, 8'd3, 32'h0000_0100, 32'h0, acc);
        for (int i = 0; i < 4; i++) begin
            check("stall_data_hold", cout_data, m_head(1'b1, 8'd3, 32'h0000_0100, 32'h0));
            step(1);
        end
        check("stall_no_wr", 134'(wr_cnt), 134'(0));
        cin_ready = 1'b1;
        step(4);
        check("stall_beats", 134'(wr_cnt), 134'(2));
        check("stall_queue_empty", 134'(exp_beats.size()), 134'(0));
        exp_rsp.push_back({1'b0, 32'hCAFE_F00D});
        send_beat(m_resp(8'd3, 32'h0000_0100, 32'hCAFE_F00D), 1'b0);
        send_beat(m_tail(), 1'b0);
        wait_rsp("stall", 20);
        check("stall_rdata", 134'(rsp_rdata), 134'(32'hCAFE_F00D));

        // Read timeout.
        do_reset();
        exp_rsp.push_back({1'b1, 32'hFFFF_FFFF});
        issue(1'b1, 8'd9, 32'h0000_0040, 32'h0, acc);
        wait_rsp("to", TO + 50);
        check("to_latency", 134'(rsp_cyc - acc), 134'(3 + TO));
        check("to_rdata", 134'(rsp_rdata), 134'(32'hFFFF_FFFF));
        check("to_err", 134'(rsp_err), 134'(1));

        // Wrong-address response is dropped, then the real one completes.
        do_reset();
        exp_rsp.push_back({1'b0, 32'hABCD_0123});
        issue(1'b1, 8'd7, 32'h7000_0020, 32'h0, acc);
        step(3);
        send_beat(m_resp(8'd7, 32'h7000_0024, 32'h1111_1111), 1'b1);
        send_beat(m_tail(), 1'b1);
        send_beat(m_resp(8'd7, 32'h7000_0020, 32'hABCD_0123), 1'b0);
        send_beat(m_tail(), 1'b0);
        wait_rsp("wa", 20);
        check("wa_drop", 134'(drop_cnt), 134'(2));
        check("wa_rdata", 134'(rsp_rdata), 134'(32'hABCD_0123));

        // Reset while waiting: no completion, late response dropped.
        do_reset();
        issue(1'b1, 8'd7, 32'h7000_0030, 32'h0, acc);
        step(5);
        do_reset();
        check("rr_drop_after_rst", 134'(drop_cnt), 134'(0));
        send_beat(m_resp(8'd7, 32'h7000_0030, 32'h0000_0077), 1'b1);
        send_beat(m_tail(), 1'b1);
        step(5);
        check("rr_drop", 134'(drop_cnt), 134'(2));
        check("rr_no_rsp", 134'(rsp_seen), 134'(0));
        check("rr_idle", 134'(cmd_ready), 134'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
